// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and sizing helper for the binary-to-BCD encoder.
package bcd_pkg;

  localparam int unsigned BCD_W     = 4;
  localparam logic [3:0]  BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_e;

  // Number of BCD digits needed to hold 2^bin_width-1 (8->3, 16->5).
  function automatic int int_digits(input int bin_width);
    return (bin_width * 3) / 10 + 1;
  endfunction

endpackage

// File: rtl/bcd_add3_adjust.sv
// One double-dabble correction stage: a digit of 5 or more gets +3 before the shift.
module bcd_add3_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  output logic [BCD_W-1:0] o_digit
);

  // 4-bit add; the carry is dropped because a valid input digit never exceeds 9.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_encoder.sv
// Sequential shift-and-add-3 binary-to-BCD encoder with a valid/ready input and
// held packed BCD output for the 7-segment decoders.
module bin_to_bcd_encoder
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIN_WIDTH-1:0]   bin_in,
  output logic [4*DIGITS-1:0]    digits_out,
  output logic                   overflow,
  output logic                   done
);

  localparam int INT_DIGITS = int_digits(BIN_WIDTH);
  localparam int CNT_W      = $clog2(BIN_WIDTH + 1);
  // Scratch is zero-extended to at least DIGITS digits so the output slice and
  // the overflow test are valid whichever of DIGITS/INT_DIGITS is larger.
  localparam int PAD_D      = (DIGITS > INT_DIGITS) ? DIGITS : INT_DIGITS;

  state_e                     r_state;
  state_e                     w_state_next;
  logic [BCD_W*INT_DIGITS-1:0] r_bcd;
  logic [BCD_W*INT_DIGITS-1:0] w_adj;
  logic [BIN_WIDTH-1:0]       r_shift;
  logic [CNT_W-1:0]           r_cnt;
  logic [BCD_W*PAD_D-1:0]     w_pad;
  logic [4*DIGITS-1:0]        w_digits_next;
  logic                       w_ovf;
  logic [4*DIGITS-1:0]        r_digits;
  logic                       r_ovf;
  logic                       r_done;

  genvar g;
  generate
    for (g = 0; g < INT_DIGITS; g++) begin : g_adj
      bcd_add3_adjust u_adj (
        .i_digit (r_bcd[BCD_W*g +: BCD_W]),
        .o_digit (w_adj[BCD_W*g +: BCD_W])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: accept in IDLE, BIN_WIDTH shifts, one publish cycle.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_state_next = SHIFT;
      SHIFT:   if (r_cnt == CNT_W'(BIN_WIDTH - 1)) w_state_next = FINISH;
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = (r_state == IDLE);
  end

  // Scratch datapath: load on accept, adjust-then-shift while in SHIFT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcd   <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_bcd   <= '0;
        r_shift <= bin_in;
        r_cnt   <= '0;
      end else if (r_state == SHIFT) begin
        r_bcd   <= {w_adj[BCD_W*INT_DIGITS-2:0], r_shift[BIN_WIDTH-1]};
        r_shift <= {r_shift[BIN_WIDTH-2:0], 1'b0};
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Result formatting: digits beyond DIGITS flag overflow and blank the display.
  always_comb begin
    w_pad         = (BCD_W*PAD_D)'(r_bcd);
    w_ovf         = |(w_pad >> (BCD_W*DIGITS));
    w_digits_next = w_pad[4*DIGITS-1:0];
    if (w_ovf) begin
      w_digits_next = {DIGITS{BCD_BLANK}};
    end
  end

  // Output registers: updated only in FINISH, with a single-cycle done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digits <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == FINISH);
      if (r_state == FINISH) begin
        r_digits <= w_digits_next;
        r_ovf    <= w_ovf;
      end
    end
  end

  assign digits_out = r_digits;
  assign overflow   = r_ovf;
  assign done       = r_done;

endmodule

// File: tb/tb_bin_to_bcd_encoder.sv
// Directed-vector bench for bin_to_bcd_encoder (DIGITS=2 and DIGITS=3 instances).
module tb_bin_to_bcd_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid,  in_valid3;
  logic        in_ready,  in_ready3;
  logic [7:0]  bin_in,    bin_in3;
  logic [7:0]  digits_out;
  logic [11:0] digits_out3;
  logic        overflow,  overflow3;
  logic        done,      done3;

  int n_tests = 0;
  int n_fail  = 0;

  bin_to_bcd_encoder #(.BIN_WIDTH(8), .DIGITS(2)) u_dut (
    .clk        (clk),
    .reset      (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bin_in     (bin_in),
    .digits_out (digits_out),
    .overflow   (overflow),
    .done       (done)
  );

  bin_to_bcd_encoder #(.BIN_WIDTH(8), .DIGITS(3)) u_dut3 (
    .clk        (clk),
    .reset      (rst),
    .in_valid   (in_valid3),
    .in_ready   (in_ready3),
    .bin_in     (bin_in3),
    .digits_out (digits_out3),
    .overflow   (overflow3),
    .done       (done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input bit sel3, input string tag);
    int n = 0;
    while (((sel3 ? in_ready3 : in_ready) !== 1'b1) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_rdy"}, 32'(sel3 ? in_ready3 : in_ready), 32'd1);
  endtask

  task automatic run_conv(input bit sel3, input logic [7:0] v, input logic [11:0] exp_d,
                          input logic exp_o, input string tag);
    int cyc;
    bit got;
    wait_idle(sel3, tag);
    if (sel3) begin in_valid3 = 1'b1; bin_in3 = v; end
    else      begin in_valid  = 1'b1; bin_in  = v; end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_valid3 = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      got = sel3 ? done3 : done;
    end
    check_eq({tag, "_lat"}, 32'(cyc), 32'd9);
    check_eq({tag, "_dig"}, 32'(sel3 ? digits_out3 : {4'h0, digits_out}), 32'(exp_d));
    check_eq({tag, "_ovf"}, 32'(sel3 ? overflow3 : overflow), 32'(exp_o));
    @(posedge clk); #1;
    check_eq({tag, "_donelo"}, 32'(sel3 ? done3 : done), 32'd0);
  endtask

  initial begin
    int cyc;
    int seen;
    rst = 1'b1;
    in_valid = 1'b0; in_valid3 = 1'b0;
    bin_in = '0; bin_in3 = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rdy",  32'(in_ready),   32'd1);
    check_eq("rst_dig",  32'(digits_out), 32'h00);
    check_eq("rst_ovf",  32'(overflow),   32'd0);
    check_eq("rst_done", 32'(done),       32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_rdy",  32'(in_ready),   32'd1);
    check_eq("idle_dig",  32'(digits_out), 32'h00);
    check_eq("idle_done", 32'(done),       32'd0);

    // Basic conversion, then output holds while bin_in moves.
    run_conv(1'b0, 8'd42, 12'h042, 1'b0, "v42");
    bin_in = 8'd99;
    repeat (3) @(posedge clk);
    #1;
    check_eq("v42_hold", 32'(digits_out), 32'h42);

    run_conv(1'b0, 8'd0,   12'h000, 1'b0, "v0");
    run_conv(1'b0, 8'd9,   12'h009, 1'b0, "v9");
    run_conv(1'b0, 8'd10,  12'h010, 1'b0, "v10");
    run_conv(1'b0, 8'd99,  12'h099, 1'b0, "v99");
    run_conv(1'b0, 8'd100, 12'h0FF, 1'b1, "v100");
    run_conv(1'b0, 8'd255, 12'h0FF, 1'b1, "v255");
    run_conv(1'b0, 8'd37,  12'h037, 1'b0, "v37");
    run_conv(1'b1, 8'd255, 12'h255, 1'b0, "d3_255");
    run_conv(1'b1, 8'd100, 12'h100, 1'b0, "d3_100");

    // Held request: busy-time bin_in change ignored, second accept in the done cycle.
    wait_idle(1'b0, "b2b");
    in_valid = 1'b1;
    bin_in   = 8'd12;
    @(posedge clk); #1;
    check_eq("b2b_busy", 32'(in_ready), 32'd0);
    cyc = 1;
    @(posedge clk); #1;
    bin_in = 8'd34;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("b2b_lat1", 32'(cyc), 32'd9);
    check_eq("b2b_dig1", 32'(digits_out), 32'h12);
    check_eq("b2b_rdy",  32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("b2b_period", 32'(cyc), 32'd10);
    check_eq("b2b_dig2",   32'(digits_out), 32'h34);

    // Reset in the middle of a conversion.
    wait_idle(1'b0, "mrst");
    in_valid = 1'b1;
    bin_in   = 8'd99;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mrst_dig",  32'(digits_out), 32'h00);
    check_eq("mrst_ovf",  32'(overflow),   32'd0);
    check_eq("mrst_rdy",  32'(in_ready),   32'd1);
    check_eq("mrst_done", 32'(done),       32'd0);
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (i == 1) rst = 1'b0;
      if (done) seen++;
    end
    check_eq("mrst_nodone", 32'(seen), 32'd0);
    run_conv(1'b0, 8'd57, 12'h057, 1'b0, "v57");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
